// File: rtl/fetch_pkg.sv
// fetch_pkg: redirect kinds, fetch FSM encoding and default reset vector for fetch_unit
package fetch_pkg;
  localparam logic [1:0] RK_BRANCH = 2'b00;
  localparam logic [1:0] RK_JUMP = 2'b01;
  localparam logic [1:0] RK_JR = 2'b10;
  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: instruction FIFO with wrap-around pointers, occupancy count and synchronous flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clock,
  input logic reset_n,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  // pointers and occupancy; flush empties the queue regardless of push/pop
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage array, written at the tail
  always_ff @(posedge clock)
    if (push && !flush) mem[wp] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: registered-PC fetch sequencer with imem handshake, instruction queue and redirects; FETCH_HALT_ON_ZERO_EN halts on a zero instruction
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [31:0] RESET_PC = RESET_VEC,
  parameter int QDEPTH = 4
) (
  input logic clock,
  input logic reset_n,
  output logic imem_req_valid,
  input logic imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input logic imem_rsp_valid,
  input logic [DATA_W-1:0] imem_rsp_data,
  input logic redirect_valid,
  input logic [1:0] redirect_kind,
  input logic [ADDR_W-1:0] redirect_pc,
  input logic [25:0] redirect_imm,
  input logic [ADDR_W-1:0] redirect_reg,
  output logic inst_valid,
  input logic inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic halted
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] LOW28 = ADDR_W'(32'h0FFF_FFFF);
  state_t state, state_n;
  logic [ADDR_W-1:0] fetch_pc, pc_n, pc4, target;
  logic discard, disc_n, redir, acc, rsp, keep, zero, q_full, q_empty;
  logic [CW-1:0] q_count;
  assign pc4 = redirect_pc + ADDR_W'(4);
  assign target = redirect_kind == RK_BRANCH ? pc4 + {{(ADDR_W-18){redirect_imm[15]}}, redirect_imm[15:0], 2'b00}
                : redirect_kind == RK_JUMP ? (pc4 & ~LOW28) | ADDR_W'({redirect_imm, 2'b00})
                : redirect_reg;
  assign redir = redirect_valid && (redirect_kind == RK_BRANCH || redirect_kind == RK_JUMP || redirect_kind == RK_JR);
  assign imem_req_valid = reset_n && state == S_REQ && q_count < CW'(QDEPTH);
  assign imem_req_addr = fetch_pc;
  assign inst_valid = !q_empty;
`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero = imem_rsp_data == '0;
  assign halted = state == S_HALT;
`else
  assign zero = 1'b0;
  assign halted = 1'b0;
`endif
  // next state: a redirect overrides the response path and arms discard if a request is in flight
  always_comb begin
    acc = imem_req_valid && imem_req_ready;
    rsp = state == S_WAIT && imem_rsp_valid;
    keep = rsp && !discard && !redir && !zero;
    state_n = acc ? S_WAIT : state;
    pc_n = keep ? fetch_pc + ADDR_W'(4) : fetch_pc;
    disc_n = rsp ? 1'b0 : discard;
    if (rsp) state_n = (discard || redir || !zero) ? S_REQ : S_HALT;
    if (redir) begin
      pc_n = target;
      disc_n = acc || (state == S_WAIT && !imem_rsp_valid);
      state_n = disc_n ? S_WAIT : S_REQ;
    end
  end
  // fetch state, PC and discard flag
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= S_REQ;
      fetch_pc <= ADDR_W'(RESET_PC);
      discard <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= pc_n;
      discard <= disc_n;
    end
  fetch_queue #(.W(ADDR_W + DATA_W), .DEPTH(QDEPTH)) u_queue (
    .clock(clock),
    .reset_n(reset_n),
    .push(keep && !q_full),
    .pop(inst_ready && !q_empty),
    .flush(redir),
    .din({fetch_pc, imem_rsp_data}),
    .dout({inst_pc, inst_data}),
    .full(q_full),
    .empty(q_empty),
    .count(q_count)
  );
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch sequencer for the MIPS datapath. It replaces the free-running PC/add4/jump-mux chain with a registered fetch PC and a valid/ready instruction-memory request/response handshake. Fetched instructions are buffered in a small queue, and branch, jump and jump-register targets are computed internally from a single redirect port. It sits between instruction memory and the decode/control stage.

## Interface
- `ADDR_W`, 32: address/PC width; must be ≥ 28.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 32'h00400000: fetch address after reset, truncated to `ADDR_W`.
- `QDEPTH`, 4: instruction-queue entries; power of two, ≥ 2.
- `clock`, in, 1: sole clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request this cycle.
- `imem_req_addr`, out, `ADDR_W`: byte address of the fetch.
- `imem_rsp_valid`, in, 1: response data valid.
- `imem_rsp_data`, in, `DATA_W`: fetched instruction.
- `redirect_valid`, in, 1: control-flow change this cycle.
- `redirect_kind`, in, 2: 00 BRANCH, 01 JUMP, 10 JR, 11 reserved (ignored).
- `redirect_pc`, in, `ADDR_W`: PC of the redirecting instruction.
- `redirect_imm`, in, 26: BRANCH uses [15:0]; JUMP uses [25:0].
- `redirect_reg`, in, `ADDR_W`: JR target.
- `inst_valid`, out, 1: queue head valid.
- `inst_ready`, in, 1: consumer pops the head.
- `inst_data`, out, `DATA_W`: head instruction.
- `inst_pc`, out, `ADDR_W`: PC of the head instruction.
- `halted`, out, 1: fetch stopped on a zero instruction (see Configuration).

## Operation
- **States:** S_REQ, S_WAIT, S_HALT.
  - S_REQ asserts `imem_req_valid` with `imem_req_addr` = `fetch_pc`.
  - Accept (`valid && ready`) leads to S_WAIT.
- **Credit rule:** `imem_req_valid` is asserted only if queue occupancy + outstanding < `QDEPTH`. At most one request is outstanding.
- **S_WAIT:**
  - On `imem_rsp_valid`, enqueue {`fetch_pc`, data}.
  - `fetch_pc` += 4, modulo 2^`ADDR_W`.
  - Return to S_REQ.
- **Target arithmetic** (`pc4` = `redirect_pc` + 4):
  - BRANCH: `pc4` + (sign-extend(imm[15:0]) << 2), truncated to `ADDR_W`.
  - JUMP: {`pc4`[`ADDR_W`-1:28], imm[25:0], 2'b00}.
  - JR: `redirect_reg`, used as-is.
- **Redirect (kind ≠ 11):**
  - Flush the queue and load `fetch_pc` with the target.
  - If a request is outstanding, or is accepted in the same cycle, set `discard`. The next response is then dropped and clears `discard`.
  - Next state is S_REQ, or S_WAIT if outstanding.
  - A redirect while in S_REQ before acceptance simply retargets the address the next cycle. Memory tolerates a change of address on an unaccepted request.
- **Simultaneous events:**
  - Redirect with a pop: the redirect wins and the queue is empty next cycle.
  - Enqueue and pop in the same cycle: occupancy is unchanged.
  - Redirect with a response: the response is dropped.
- **Queue:** FIFO with wrap-around pointers.
  - Never overflows, because of the credit rule.
  - `inst_valid` = 0 when empty; `inst_data`/`inst_pc` are don't-care when empty.

## Timing
- **Reset values** (asynchronous on `reset_n` low):
  - `imem_req_valid` = 0, `inst_valid` = 0, `halted` = 0.
  - `fetch_pc` = `RESET_PC`, queue empty, `discard` = 0, state S_REQ.
- The first cycle after `reset_n` rises: `imem_req_valid` = 1, `imem_req_addr` = `RESET_PC`.
- A response in cycle N gives `inst_valid` in N+1 (registered queue). The earliest next request is in N+1.
- Peak throughput: 1 instruction per 2 cycles with zero-wait memory.
- A redirect in cycle N gives a request at the target in N+1, unless a request is still outstanding.
- Reset asserted mid-transaction abandons the outstanding request. Any response before the first post-reset request is ignored.

## Configuration
- **`FETCH_HALT_ON_ZERO_EN` defined:**
  - A non-discarded response equal to 0 is not enqueued.
  - The state goes to S_HALT and `halted` = 1 from the next cycle.
  - No requests are issued while in S_HALT. The queue drains normally.
  - A redirect leaves S_HALT: `halted` = 0 and fetch starts at the target.
- **Undefined:** a zero instruction is enqueued like any other; S_HALT is unreachable and `halted` is tied to 0.

## Structure
- **Package `fetch_pkg`:**
  - Redirect-kind constants: `RK_BRANCH`, `RK_JUMP`, `RK_JR`.
  - State encoding.
  - Default reset vector, 32'h00400000.
- **Sub-module `fetch_queue`:** parametrised FIFO of width `ADDR_W`+`DATA_W` and depth `QDEPTH`. Ports: push, pop, flush, full, empty, count.
- Target calculation stays inline in `fetch_unit`.

## Test plan
- **Reset then straight-line fetch:**
  - Stimulus: memory with one-cycle latency returns 0x20080001, 0x20090002; `inst_ready` = 1.
  - Required: requests at 0x00400000 and 0x00400004; `inst_pc` 0x00400000 then 0x00400004, two cycles apart.
- **Backpressure:**
  - Stimulus: `inst_ready` = 0 for 20 cycles.
  - Required: exactly `QDEPTH` = 4 requests issued, then `imem_req_valid` stays 0. After release, order 0x00400000 to 0x0040000C is preserved.
- **BRANCH:**
  - Stimulus: `redirect_pc` = 0x00400008, imm = 16'hFFFE, arriving while a response is outstanding.
  - Required: target 0x00400004; the stale response is dropped; the queue is empty; the next `inst_pc` = 0x00400004.
- **JUMP and JR:**
  - JUMP: `redirect_pc` = 0x0040000C, imm = 26'h0100005 gives request 0x00400014.
  - JR: `redirect_reg` = 0x00400020 gives request 0x00400020.
- **Simultaneous events:**
  - Redirect + pop + response in the same cycle: next cycle `inst_valid` = 0 and the response is not enqueued.
  - `reset_n` pulsed low mid-wait: `imem_req_addr` returns to 0x00400000.
- **Halt on zero:**
  - With `FETCH_HALT_ON_ZERO_EN`, a response of 0 at 0x00400008: `halted` = 1, no further requests, queue holds 2 entries.
  - A subsequent JR to 0x00400000 clears `halted`.
  - Without the macro, the zero is enqueued with `inst_pc` 0x00400008.
